// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: op-codes, ALU latency,
// result type and a reference model of the ALU arithmetic.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int ALU_LATENCY = 1;

  typedef struct packed {
    logic       c;
    logic [7:0] y;
  } alu_res_t;

  // Sub uses the 8-bit two's complement of B, so B=0 yields no carry.
  function automatic alu_res_t alu_ref(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [1:0] sel);
    logic [7:0] nb;
    logic [8:0] s;
    nb = ~b + 8'd1;
    case (sel)
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      OP_SUB:  s = {1'b0, a} + {1'b0, nb};
      OP_AND:  s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return alu_res_t'(s);
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Show-ahead response FIFO with occupancy count; when empty the output
// holds the last entry popped (zero after reset).
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  hold_q;
  logic          pop_ok;

  assign pop_ok   = pop & (count != '0);
  assign head_dat = (count != '0) ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Drives commands into the registered ALU and buffers {C,Y,tag} results in order.
// Optional result checker enabled by defining ALU_CHECK_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [1:0]       cmd_sel,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [1:0]       alu_sel,
  input  logic [7:0]       alu_y,
  input  logic             alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_y,
  output logic             rsp_c,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef ALU_CHECK_EN
  ,
  output logic             chk_err,
  output logic [7:0]       chk_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  typedef struct packed {
    logic             c;
    logic [7:0]       y;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic             s1, s2;
  logic [TAG_W-1:0] tag1, tag2;
  logic             hs;
  logic [CW-1:0]    count;
  logic [SW-1:0]    inflight;
  rsp_t             push_dat;
  rsp_t             head;

  // Every accepted command owns a FIFO slot until its response is popped.
  assign inflight  = SW'(count) + SW'(s1) + SW'(s2);
  assign cmd_ready = rst & (inflight < SW'(DEPTH));
  assign hs        = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      tag1    <= '0;
      tag2    <= '0;
    end else begin
      s1   <= hs;
      s2   <= s1;
      tag2 <= tag1;
      if (hs) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_sel;
        tag1    <= cmd_tag;
      end
    end
  end

  assign push_dat = '{c: alu_c, y: alu_y, tag: tag2};

  alu_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rsp_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (s2),
    .push_dat (push_dat),
    .pop      (rsp_ready),
    .head_dat (head),
    .count    (count)
  );

  assign rsp_valid = (count != '0);
  assign rsp_y     = head.y;
  assign rsp_c     = head.c;
  assign rsp_tag   = head.tag;
  assign busy      = s1 | s2 | (count != '0);

`ifdef ALU_CHECK_EN
  alu_res_t exp2;

  // Expected result is taken from the held stage-1 operands, aligned with s2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp2    <= '0;
      chk_err <= 1'b0;
      chk_cnt <= '0;
    end else begin
      exp2 <= alu_ref(alu_a, alu_b, alu_sel);
      if (s2 && ({alu_c, alu_y} != exp2)) begin
        chk_err <= 1'b1;
        if (chk_cnt != 8'hFF) chk_cnt <= chk_cnt + 8'd1;
      end
    end
  end
`endif

endmodule
